seed_key_sched: RTL and testbench
=================================

// Module: seed_key_sched
// PURPOSE
// - SEED-128 key schedule: expands a 128-bit user key into 16 round keys {K_i0,K_i1} (64b each).
// - Sits directly upstream of the SEED round core, which pulls one round key per round via i_fNext.
// - Keys are buffered in a 16x64 table; served in order 1..16 for encryption, 16..1 for decryption.
// - A retained table is reused without re-expansion.
// PARAMETERS
// - KC0   32'h9E37_79B9   base round constant; KC_j = KC0 <<< j, j = 0..15
// - NRND  16              number of rounds; fixed, no other value supported
// PORTS
// - i_Clk      in   1    clock; all state on rising edge
// - i_Rst      in   1    asynchronous, active-low reset
// - i_Key      in   128  user key {A,B,C,D}, A = [127:96]; sampled only at accepted start
// - i_fStart   in   1    start request; accepted only in IDLE
// - i_fNewKey  in   1    qualifies i_fStart: 1 = expand i_Key, 0 = reuse stored table
// - i_Dec      in   1    qualifies i_fStart: 1 = serve keys 16..1, 0 = 1..16
// - i_fNext    in   1    round core consumed o_RKey; advance to next key
// - o_RKey     out  64   current round key {K_i0,K_i1}; 0 when o_fValid = 0
// - o_Round    out  4    index of served key minus 1 (0..15)
// - o_fValid   out  1    o_RKey/o_Round valid (SERVE state)
// - o_fBusy    out  1    1 in EXPAND or SERVE
// - o_fDone    out  1    one-cycle pulse after the 16th key is consumed
// BEHAVIOUR
// - Reset: state IDLE, counters 0, A/B/C/D regs 0, table-valid flag 0; all outputs 0. Table contents not cleared.
// - FSM states: IDLE, EXPAND, SERVE, DONE.
// - IDLE: on i_fStart:
//   - i_fNewKey = 1: latch {A,B,C,D} = i_Key, latch dec, clear table-valid, go to EXPAND.
//   - i_fNewKey = 0 and table valid: latch dec, go to SERVE.
//   - i_fNewKey = 0 and table not valid: treated as i_fNewKey = 1.
// - EXPAND: 16 cycles, counter j = 0..15; each cycle:
//   - table[j] <= {G(A+C-KC_j), G(B-D+KC_j)}; mod 2^32 add/sub, KC_j = KC0 <<< j.
//   - j even: {A,B} <= {A,B} >>> 8 (64b rotate right).
//   - j odd: {C,D} <= {C,D} <<< 8 (64b rotate left).
//   - At j = 15: set table-valid, go to SERVE.
//   - Latency from accepted start to first o_fValid: 17 cycles (new key), 1 cycle (reuse).
// - SERVE: counter k = 0..15, pointer p = dec ? 15-k : k.
//   - o_RKey = table[p], o_Round = p, o_fValid = 1 (registered or table-direct, no extra cycle).
//   - i_fNext: k <= k+1. i_fNext at k = 15: go to DONE.
//   - No i_fNext: key held stable indefinitely.
// - DONE: o_fDone = 1 for one cycle, o_fValid = 0; next state IDLE.
// - Ignored inputs:
//   - i_fStart outside IDLE. i_fNext outside SERVE.
//   - i_Key/i_Dec/i_fNewKey changes after acceptance have no effect.
// - Reset mid-EXPAND or mid-SERVE: immediate IDLE, table-valid 0; next start must re-expand.
// - o_fBusy = EXPAND | SERVE. o_fDone never coincides with o_fValid.
// STRUCTURE
// - Shared package seed_pkg: KC0, NRND, state encoding, S1/S2 S-box tables, G masks 8'hFC/F3/CF/3F.
// - Sub-module seed_g_func (combinational 32b G function, S-box + mask mix). Shared with the round core's F function.
// - Two seed_g_func instances here, one per key half. The table is a plain reg array.
// TESTING
// - Key 128'h0, enc:
//   - start -> o_fValid rises 17 cycles later with o_RKey = 64'h7C8F8C7E_C737A22C, o_Round = 0.
// - Same key, enc, i_fNext every cycle:
//   - 16 keys, o_Round 0..15; o_fDone one cycle after the last i_fNext.
//   - All 16 keys match the golden model.
// - Reuse, dec: i_fStart with i_fNewKey = 0, i_Dec = 1.
//   - o_fValid after 1 cycle, o_Round = 15, o_RKey = table[15].
//   - Keys descend to o_Round = 0; no EXPAND cycles.
// - Stall: hold i_fNext = 0 for 5 cycles in SERVE -> o_RKey/o_Round unchanged.
// - Spurious i_fStart mid-SERVE and i_fNext in IDLE -> no state change.
// - Reset mid-EXPAND at j = 7, then reuse start (i_fNewKey = 0):
//   - block performs a full EXPAND (17-cycle latency); no stale keys served.

Source files
------------

// File: rtl/seed_pkg.sv
// Shared SEED definitions: round constant, state encoding, S-boxes and G-function masks.
// Used by the key schedule and by the round core's F function.
package seed_pkg;

  localparam logic [31:0] KC0  = 32'h9E37_79B9;
  localparam int          NRND = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_SERVE, ST_DONE} state_t;

  // G mixing masks, index n applies to S-box output byte n for output byte 0
  localparam logic [3:0][7:0] G_MASK = {8'h3F, 8'hCF, 8'hF3, 8'hFC};

  // Entry 0 sits in the most significant byte
  localparam logic [2047:0] S1_TAB = {
    128'hA985D6D3541DAC255D43181E51FCCA63, 128'h2844209DE0E2C817A58F037BBB13D2EE,
    128'h708C3FA832DDF674EC950B575C5BBD01, 128'h241C739810CCF2D92CE772839BD186C9,
    128'h6050A3EB0DB69E4FB75AC678A612AFD5, 128'h61C3B441527D8D081F9900190453F7E1,
    128'hFD762F27B08B0EABA26E934D697C090A, 128'hBFEFF3C58714FE64DE2E4B1A06216B66,
    128'h02F5928A0CB37ED07A4796E52680ADDF, 128'hA13037AE36152238F4A7454C81E98497,
    128'h35CBCE3C7111C78975FBDAF8945982C4, 128'hFF493967C0CFD7B80F8E4223916CDBA4,
    128'h34F148C26F3D2D40BE3EBCC1AABA4E55, 128'h3BDC687F9CD84A5677A0ED46B52B65FA,
    128'hE3B9B19F5EF9E6B231EA6D5FE4F0CD88, 128'h163A58D462290733E81B0579906A2A9A
  };

  localparam logic [2047:0] S2_TAB = {
    128'h38E82DA6CFDEB3B8AF6055C7446F6B5B, 128'hC36233B529A0E2A7D39111061CBC364B,
    128'hEF886CA817C416F4C245E1D63F3D8E98, 128'h284EF63EA5F90DDFD82B667A272FF172,
    128'h42D441C07367AC8BF7AD801FCA2CAA34, 128'hD20BEEE95D9418F857AE08C513CD86B9,
    128'hFF7DC131F58A6AB1D120D70222046871, 128'h07DB9D9961BEE659DD5190DC9AA3ABD0,
    128'h810F471AE3EC8DBF967B5CA2A163234D, 128'hC89E9C3A0C2EBA6E9F5AF292F34978CC,
    128'h15FB70757F351003646DC674D5B4EA09, 128'h7619FE4012E0BD05FA01F02A5EA95643,
    128'h8514899BB0E5487997FC1E82218C1B5F, 128'h7754B21D254F0046ED5852EB7EDAC9FD,
    128'h3095653CB6E4BB7C0E50392632846993, 128'h37E724A4CB530A87D94C838FCE3B4AB7
  };

  function automatic logic [7:0] s1(input logic [7:0] x);
    return S1_TAB[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] s2(input logic [7:0] x);
    return S2_TAB[{~x, 3'b000} +: 8];
  endfunction

  // KC_j = KC0 rotated left by j
  function automatic logic [31:0] kc(input logic [3:0] j);
    logic [63:0] t;
    t = {KC0, KC0} << j;
    return t[63:32];
  endfunction

endpackage

// File: rtl/seed_g_func.sv
// SEED G function: four S-box lookups followed by the masked byte mix.
module seed_g_func
  import seed_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [3:0][7:0] sb;

  assign sb[0] = s1(x[7:0]);
  assign sb[1] = s2(x[15:8]);
  assign sb[2] = s1(x[23:16]);
  assign sb[3] = s2(x[31:24]);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign y[gi*8 +: 8] = (sb[0] & G_MASK[gi])
                          ^ (sb[1] & G_MASK[(gi + 1) % 4])
                          ^ (sb[2] & G_MASK[(gi + 2) % 4])
                          ^ (sb[3] & G_MASK[(gi + 3) % 4]);
    end
  endgenerate

endmodule

// File: rtl/seed_key_sched.sv
// SEED-128 key schedule: expands a user key into a 16-entry round-key table and
// serves it to the round core in encryption or decryption order.
module seed_key_sched
  import seed_pkg::*;
(
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [127:0] i_Key,
  input  logic         i_fStart,
  input  logic         i_fNewKey,
  input  logic         i_Dec,
  input  logic         i_fNext,
  output logic [63:0]  o_RKey,
  output logic [3:0]   o_Round,
  output logic         o_fValid,
  output logic         o_fBusy,
  output logic         o_fDone
);

  state_t      state_reg;
  logic [31:0] a_reg, b_reg, c_reg, d_reg;
  logic [3:0]  j_reg, k_reg;
  logic        dec_reg, tbl_valid_reg, valid_reg, busy_reg, done_reg;
  logic [63:0] rk_table [NRND];

  logic [31:0] kc_cur, g0_in, g1_in, g0_out, g1_out;
  logic [3:0]  ptr;

  assign kc_cur = kc(j_reg);
  assign g0_in  = a_reg + c_reg - kc_cur;
  assign g1_in  = b_reg - d_reg + kc_cur;

  seed_g_func u_g0 (.x(g0_in), .y(g0_out));
  seed_g_func u_g1 (.x(g1_in), .y(g1_out));

  // Table holds its contents across reset; only the valid flag is cleared
  always_ff @(posedge i_Clk) begin
    if (state_reg == ST_EXPAND)
      rk_table[j_reg] <= {g0_out, g1_out};
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      d_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      dec_reg       <= 1'b0;
      tbl_valid_reg <= 1'b0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_fStart) begin
            dec_reg  <= i_Dec;
            busy_reg <= 1'b1;
            // A reuse request without a valid table falls back to expansion
            if (i_fNewKey || !tbl_valid_reg) begin
              {a_reg, b_reg, c_reg, d_reg} <= i_Key;
              tbl_valid_reg <= 1'b0;
              j_reg         <= '0;
              state_reg     <= ST_EXPAND;
            end else begin
              k_reg     <= '0;
              valid_reg <= 1'b1;
              state_reg <= ST_SERVE;
            end
          end
        end
        ST_EXPAND: begin
          if (!j_reg[0])
            {a_reg, b_reg} <= {b_reg[7:0], a_reg, b_reg[31:8]};
          else
            {c_reg, d_reg} <= {c_reg[23:0], d_reg, c_reg[31:24]};
          if (j_reg == 4'(NRND - 1)) begin
            tbl_valid_reg <= 1'b1;
            k_reg         <= '0;
            valid_reg     <= 1'b1;
            state_reg     <= ST_SERVE;
          end else begin
            j_reg <= j_reg + 4'd1;
          end
        end
        ST_SERVE: begin
          if (i_fNext) begin
            if (k_reg == 4'(NRND - 1)) begin
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              k_reg <= k_reg + 4'd1;
            end
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ptr      = dec_reg ? ~k_reg : k_reg;
  assign o_fValid = valid_reg;
  assign o_fBusy  = busy_reg;
  assign o_fDone  = done_reg;
  assign o_Round  = valid_reg ? ptr : 4'd0;
  assign o_RKey   = valid_reg ? rk_table[ptr] : 64'd0;

endmodule

// File: tb/tb_seed_key_sched.sv
// Directed plus randomized bench for seed_key_sched against a behavioural key-schedule model.
module tb_seed_key_sched;
  import seed_pkg::*;

  logic         i_Clk = 1'b0;
  logic         i_Rst = 1'b0;
  logic [127:0] i_Key = '0;
  logic         i_fStart = 1'b0;
  logic         i_fNewKey = 1'b0;
  logic         i_Dec = 1'b0;
  logic         i_fNext = 1'b0;
  logic [63:0]  o_RKey;
  logic [3:0]   o_Round;
  logic         o_fValid, o_fBusy, o_fDone;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_rk [16];

  always #5 i_Clk = ~i_Clk;

  seed_key_sched dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Key(i_Key), .i_fStart(i_fStart),
    .i_fNewKey(i_fNewKey), .i_Dec(i_Dec), .i_fNext(i_fNext),
    .o_RKey(o_RKey), .o_Round(o_Round), .o_fValid(o_fValid),
    .o_fBusy(o_fBusy), .o_fDone(o_fDone)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] g_ref(input logic [31:0] x);
    logic [7:0]  y [4];
    logic [7:0]  m [4];
    logic [31:0] z;
    y[0] = s1(x[7:0]);   y[1] = s2(x[15:8]);
    y[2] = s1(x[23:16]); y[3] = s2(x[31:24]);
    m[0] = 8'hFC; m[1] = 8'hF3; m[2] = 8'hCF; m[3] = 8'h3F;
    z = '0;
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 4; n++)
        z[i*8 +: 8] = z[i*8 +: 8] ^ (y[n] & m[(n + i) % 4]);
    return z;
  endfunction

  task automatic build_model(input logic [127:0] key);
    logic [63:0] ab, cd;
    logic [31:0] kcj;
    ab = key[127:64];
    cd = key[63:0];
    for (int j = 0; j < 16; j++) begin
      kcj = (KC0 << j) | (KC0 >> (32 - j));
      exp_rk[j] = {g_ref(ab[63:32] + cd[63:32] - kcj), g_ref(ab[31:0] - cd[31:0] + kcj)};
      if (j % 2 == 0) ab = {ab[7:0], ab[63:8]};
      else            cd = {cd[55:0], cd[63:56]};
    end
  endtask

  // Called at a sample point (#1 after a rising edge)
  task automatic start(input logic [127:0] key, input logic newkey, input logic dec,
                       input int exp_lat, input string tag);
    int lat;
    i_Key = key; i_fNewKey = newkey; i_Dec = dec; i_fStart = 1'b1;
    @(posedge i_Clk); #1;
    i_fStart = 1'b0;
    i_Key = {$urandom, $urandom, $urandom, $urandom};
    i_Dec = ~dec; i_fNewKey = ~newkey;
    chk({tag, " busy"}, 64'(o_fBusy), 64'(1'b1));
    lat = 1;
    while (!o_fValid && lat < 40) begin
      @(posedge i_Clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    $display("start %s: key=%h new=%0d dec=%0d latency=%0d", tag, key, newkey, dec, lat);
  endtask

  task automatic serve(input logic dec, input string tag, input int stall_at,
                       input int spur_at, input int stall_max);
    int p;
    int s;
    for (int i = 0; i < 16; i++) begin
      p = dec ? 15 - i : i;
      chk({tag, " valid"}, 64'(o_fValid), 64'(1'b1));
      chk({tag, " round"}, 64'(o_Round), 64'(p));
      chk({tag, " rkey"}, o_RKey, exp_rk[p]);
      chk({tag, " done"}, 64'(o_fDone), 64'(1'b0));
      if (i == stall_at) begin
        repeat (5) begin
          @(posedge i_Clk); #1;
          chk({tag, " stall round"}, 64'(o_Round), 64'(p));
          chk({tag, " stall rkey"}, o_RKey, exp_rk[p]);
        end
      end
      if (i == spur_at) begin
        i_Key = {$urandom, $urandom, $urandom, $urandom};
        i_fNewKey = 1'b1; i_fStart = 1'b1;
        @(posedge i_Clk); #1;
        i_fStart = 1'b0;
        chk({tag, " spur round"}, 64'(o_Round), 64'(p));
        chk({tag, " spur rkey"}, o_RKey, exp_rk[p]);
        chk({tag, " spur busy"}, 64'(o_fBusy), 64'(1'b1));
      end
      if (stall_max > 0) begin
        s = $urandom_range(stall_max, 0);
        repeat (s) begin @(posedge i_Clk); #1; end
        chk({tag, " hold rkey"}, o_RKey, exp_rk[p]);
      end
      i_fNext = 1'b1;
      @(posedge i_Clk); #1;
      i_fNext = 1'b0;
    end
    chk({tag, " done pulse"}, 64'(o_fDone), 64'(1'b1));
    chk({tag, " valid at done"}, 64'(o_fValid), 64'(1'b0));
    chk({tag, " rkey at done"}, o_RKey, 64'd0);
    @(posedge i_Clk); #1;
    chk({tag, " done clear"}, 64'(o_fDone), 64'(1'b0));
    chk({tag, " idle busy"}, 64'(o_fBusy), 64'(1'b0));
    $display("serve %s: dec=%0d 16 keys", tag, dec);
  endtask

  initial begin
    logic [127:0] key;
    logic         dec;

    // Reset state
    repeat (3) @(posedge i_Clk);
    #1;
    chk("reset valid", 64'(o_fValid), 64'(1'b0));
    chk("reset busy", 64'(o_fBusy), 64'(1'b0));
    chk("reset done", 64'(o_fDone), 64'(1'b0));
    chk("reset rkey", o_RKey, 64'd0);
    chk("reset round", 64'(o_Round), 64'd0);
    i_Rst = 1'b1;
    @(posedge i_Clk); #1;

    // Known answer for the all-zero key, then full encryption pass with stall and spurious start
    build_model(128'd0);
    start(128'd0, 1'b1, 1'b0, 17, "kat");
    chk("kat rkey", o_RKey, 64'h7C8F8C7E_C737A22C);
    chk("kat round", 64'(o_Round), 64'd0);
    serve(1'b0, "enc0", 3, 6, 0);

    // i_fNext while idle has no effect
    i_fNext = 1'b1;
    repeat (3) begin
      @(posedge i_Clk); #1;
      chk("idle next busy", 64'(o_fBusy), 64'(1'b0));
      chk("idle next valid", 64'(o_fValid), 64'(1'b0));
    end
    i_fNext = 1'b0;

    // Reuse stored table in decryption order; driven key must be ignored
    start({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1, "reuse dec");
    serve(1'b1, "dec0", -1, -1, 0);

    // Randomized keys and directions, each followed by a reuse in the other direction
    for (int t = 0; t < 4; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      dec = 1'($urandom_range(1, 0));
      build_model(key);
      start(key, 1'b1, dec, 17, "rand new");
      serve(dec, "rand new", -1, -1, 2);
      start({$urandom, $urandom, $urandom, $urandom}, 1'b0, ~dec, 1, "rand reuse");
      serve(~dec, "rand reuse", -1, -1, 2);
    end

    // Reset in the middle of expansion at j = 7 invalidates the table
    i_Key = {$urandom, $urandom, $urandom, $urandom};
    i_fNewKey = 1'b1; i_Dec = 1'b0; i_fStart = 1'b1;
    @(posedge i_Clk); #1;
    i_fStart = 1'b0;
    repeat (7) @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    #1;
    chk("midreset busy", 64'(o_fBusy), 64'(1'b0));
    chk("midreset valid", 64'(o_fValid), 64'(1'b0));
    @(posedge i_Clk); #1;
    i_Rst = 1'b1;
    @(posedge i_Clk); #1;
    key = {$urandom, $urandom, $urandom, $urandom};
    build_model(key);
    start(key, 1'b0, 1'b0, 17, "post-reset reuse");
    serve(1'b0, "post-reset", -1, -1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
